// File: rtl/aes_sub_bytes_engine.sv
// -----------------------------------------------------------------------------
// aes_sub_bytes_engine
//
// Multi-cycle AES SubBytes unit. A full state word is accepted over a
// valid/ready handshake and substituted LANES bytes per cycle by LANES sbox
// lanes. The result is then held on the output handshake until it is taken.
// This unit sits between the UART frame assembler and the AES round datapath.
//
// Parameters
//   NUM_BYTES  bytes per state word (data buses are 8*NUM_BYTES bits)
//   LANES      sbox lanes, i.e. bytes substituted per cycle; must divide
//              NUM_BYTES
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   input word valid
//   in_ready   engine can accept a word (decoded from state only)
//   in_data    input state, byte i = bits [8i+7:8i]
//   in_inv     1 = inverse sbox (only when INV_SBOX_EN is defined)
//   out_valid  substituted word available
//   out_ready  consumer takes the word
//   out_data   substituted state, registered
//   busy       high while a word is being substituted or waiting in DONE
//
// Build option
//   INV_SBOX_EN  adds the in_inv port and the inverse sbox tables. The
//                direction is latched at acceptance and held for the word.
// -----------------------------------------------------------------------------
module aes_sub_bytes_engine #(
   parameter int NUM_BYTES = 16,
   parameter int LANES     = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [8*NUM_BYTES-1:0] in_data,
`ifdef INV_SBOX_EN
   input  logic                   in_inv,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*NUM_BYTES-1:0] out_data,
   output logic                   busy
);

   localparam int CHUNKS = NUM_BYTES / LANES;
   localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

   if (LANES < 1 || (NUM_BYTES % LANES) != 0) begin : g_bad_lanes
      $error("aes_sub_bytes_engine: LANES must divide NUM_BYTES");
   end

   // Element 0 is the leftmost byte of the first row.
   localparam logic [0:255][7:0] SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

`ifdef INV_SBOX_EN
   localparam logic [0:255][7:0] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };
   logic inv_q;
`endif

   typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

   state_t                   state;
   logic [CNT_W-1:0]         cnt;
   logic [8*NUM_BYTES-1:0]   data_q;
   logic [8*NUM_BYTES-1:0]   data_next;
   logic [8*LANES-1:0]       chunk_in;
   logic [8*LANES-1:0]       chunk_sub;

   // Chunk currently addressed by cnt.
   assign chunk_in = data_q[8*LANES*int'(cnt) +: 8*LANES];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef INV_SBOX_EN
      assign chunk_sub[8*l +: 8] = inv_q ? SBOX_INV[chunk_in[8*l +: 8]]
                                         : SBOX_FWD[chunk_in[8*l +: 8]];
`else
      assign chunk_sub[8*l +: 8] = SBOX_FWD[chunk_in[8*l +: 8]];
`endif
   end

   // NOTE: every variable in a combinational block gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      data_next = data_q;
      data_next[8*LANES*int'(cnt) +: 8*LANES] = chunk_sub;
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the values from before the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         data_q    <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
`ifdef INV_SBOX_EN
         inv_q     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data_q   <= in_data;
`ifdef INV_SBOX_EN
                  inv_q    <= in_inv;
`endif
                  cnt      <= '0;
                  state    <= SUB;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            SUB: begin
               data_q <= data_next;
               if (cnt == LAST_CNT) begin
                  // out_data is loaded only here, so partially substituted
                  // words never reach the output.
                  cnt       <= '0;
                  state     <= DONE;
                  out_data  <= data_next;
                  out_valid <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_sub_bytes_engine.sv
// -----------------------------------------------------------------------------
// tb_aes_sub_bytes_engine
//
// Self-checking bench for aes_sub_bytes_engine. Known-answer vectors come from
// a table; random words are checked against an sbox model derived from GF(2^8)
// inversion plus the AES affine map. Hand-written sequences cover
// backpressure, mid-word reset and the simultaneous out_ready/in_valid case.
// Build with +define+INV_SBOX_EN to exercise the inverse direction as well.
// -----------------------------------------------------------------------------
module tb_aes_sub_bytes_engine;

   localparam int NB = 16;
   localparam int LN = 4;
   localparam int CH = NB / LN;
   localparam int W  = 8 * NB;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_inv;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] fwd_tab [256];
   logic [7:0] inv_tab [256];

   always #5 clk = ~clk;

   aes_sub_bytes_engine #(.NUM_BYTES(NB), .LANES(LN)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef INV_SBOX_EN
      .in_inv    (in_inv),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; 0 maps to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r = 8'h01;
      if (a == 8'h00) return 8'h00;
      for (int i = 0; i < 254; i++) r = gf_mul(r, a);
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   function automatic logic [7:0] sbox_math(input logic [7:0] a);
      logic [7:0] x = gf_inv(a);
      return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
   endfunction

   function automatic logic [W-1:0] ref_word(input logic [W-1:0] d, input logic inv);
      logic [W-1:0] r;
      for (int i = 0; i < NB; i++)
         r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] d;
      for (int i = 0; i < NB; i++) d[8*i +: 8] = 8'($urandom_range(0, 255));
      return d;
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts and ends on a falling edge. Waits for in_ready, offers the word for
   // one cycle, scrambles the inputs after acceptance (optionally flipping
   // in_inv) and waits for out_valid. The word is left in DONE.
   task automatic send_word(input string name, input logic [W-1:0] d, input logic inv,
                            input bit toggle_inv, output logic [W-1:0] res);
      int t = 0;
      int lat = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check({name, "_in_ready"}, W'(in_ready), W'(1));
      in_data  = d;
      in_inv   = inv;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = ~d;
      if (toggle_inv) in_inv = ~inv;
      check({name, "_busy"}, W'({busy, in_ready}), W'(2'b10));
      while (!out_valid && lat < 4 * NB) begin
         @(negedge clk);
         lat++;
      end
      check({name, "_latency"}, W'(lat), W'(CH));
      res = out_data;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   typedef struct {
      string        name;
      logic [W-1:0] data;
      logic         inv;
      logic [W-1:0] exp;
   } vec_t;

   vec_t         vecs[$];
   logic [W-1:0] res;
   logic [W-1:0] d;
   logic [W-1:0] exp;
   logic         inv;

   initial begin
      for (int i = 0; i < 256; i++) fwd_tab[i] = sbox_math(8'(i));
      for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

      vecs.push_back('{"kat_zero",  {W{1'b0}},                              1'b0,
                       {NB{8'h63}}});
      vecs.push_back('{"kat_00_0f", 128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
                       128'h76abd7fe2b670130c56f6bf27b777c63});
      vecs.push_back('{"kat_53",    {NB{8'h53}},                            1'b0,
                       {NB{8'hed}}});
`ifdef INV_SBOX_EN
      vecs.push_back('{"kat_inv_63", {NB{8'h63}}, 1'b1, {W{1'b0}}});
      vecs.push_back('{"kat_inv_ed", {NB{8'hed}}, 1'b1, {NB{8'h53}}});
`endif

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_inv    = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_out_valid", W'(out_valid), W'(0));
      check("reset_out_data",  out_data,       '0);
      check("reset_busy",      W'(busy),      W'(0));
      check("reset_in_ready",  W'(in_ready),  W'(1));
      reset = 1'b0;
      @(negedge clk);

      // Known-answer table.
      foreach (vecs[i]) begin
         send_word(vecs[i].name, vecs[i].data, vecs[i].inv, 1'b0, res);
         check(vecs[i].name, res, vecs[i].exp);
         consume();
         check({vecs[i].name, "_release"}, W'({out_valid, busy, in_ready}), W'(3'b001));
      end

      // Random words against the model.
      for (int k = 0; k < 12; k++) begin
         d = rand_word();
`ifdef INV_SBOX_EN
         inv = 1'($urandom_range(0, 1));
`else
         inv = 1'b0;
`endif
         send_word("rand", d, inv, 1'b0, res);
         check("rand_data", res, ref_word(d, inv));
         consume();
      end

`ifdef INV_SBOX_EN
      // Direction flipped after acceptance must not matter.
      send_word("inv_toggle", {NB{8'hed}}, 1'b1, 1'b1, res);
      check("inv_toggle_data", res, {NB{8'h53}});
      consume();
`endif

      // Backpressure: output held for 10 cycles while in_valid pulses.
      d   = rand_word();
      exp = ref_word(d, 1'b0);
      send_word("bp", d, 1'b0, 1'b0, res);
      for (int c = 0; c < 10; c++) begin
         in_valid = (c % 2 == 0);
         in_data  = rand_word();
         @(negedge clk);
         check("bp_out_data", out_data, exp);
         check("bp_flags", W'({out_valid, in_ready, busy}), W'(3'b101));
      end
      in_valid = 1'b0;
      consume();
      repeat (CH + 3) @(negedge clk);
      check("bp_no_capture", W'({out_valid, busy, in_ready}), W'(3'b001));
      check("bp_data_kept", out_data, exp);

      // Async reset two chunks into a word.
      in_data  = rand_word();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_reset_flags", W'({out_valid, busy, in_ready}), W'(3'b001));
      check("mid_reset_data", out_data, '0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("after_reset_idle", W'({out_valid, busy, in_ready}), W'(3'b001));
      d = rand_word();
      send_word("after_reset", d, 1'b0, 1'b0, res);
      check("after_reset_data", res, ref_word(d, 1'b0));

      // out_ready and in_valid together in DONE: return to IDLE first.
      d         = rand_word();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      @(negedge clk);
      out_ready = 1'b0;
      check("simul_idle", W'({out_valid, busy, in_ready}), W'(3'b001));
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      check("simul_accept", W'({busy, in_ready}), W'(2'b10));
      for (int t = 0; t < 4 * NB && !out_valid; t++) @(negedge clk);
      check("simul_valid", W'(out_valid), W'(1));
      check("simul_data", out_data, ref_word(d, 1'b0));
      consume();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
